// File: rtl/spi_master16.sv
// 16-bit SPI master for the inertial sensor path; SCLK idles high, both sides sample on SCLK rise.
// Define SPI_MSTR_LOOPBACK_EN to sample MOSI instead of MISO for board bring-up without the sensor.
module spi_master16 #(
  parameter int DIV_BITS = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt,
  input  logic [15:0] cmd,
  input  logic        MISO,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  localparam logic [DIV_BITS-1:0] DIV_HALF = {1'b1, {(DIV_BITS-1){1'b0}}};
  localparam logic [DIV_BITS-1:0] DIV_RISE = {1'b0, {(DIV_BITS-1){1'b1}}};
  localparam logic [DIV_BITS-1:0] DIV_FALL = {DIV_BITS{1'b1}};

  state_t              state_q, state_d;
  logic [DIV_BITS-1:0] div_q, div_d;
  logic [15:0]         shreg_q, shreg_d;
  logic                smpl_q, smpl_d;
  logic [4:0]          bitcnt_q, bitcnt_d;
  logic                done_q, done_d;
  logic                ssn_q, ssn_d;
  logic                smplSrc;

`ifdef SPI_MSTR_LOOPBACK_EN
  assign smplSrc = shreg_q[15];
`else
  assign smplSrc = MISO;
`endif

  // The divider starts at half scale so the first fall lands half a period after SS_n drops (front porch).
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    shreg_d  = shreg_q;
    smpl_d   = smpl_q;
    bitcnt_d = bitcnt_q;
    done_d   = done_q;
    ssn_d    = ssn_q;
    case (state_q)
      IDLE: begin
        ssn_d = 1'b1;
        if (wrt) begin
          shreg_d  = cmd;
          div_d    = DIV_HALF;
          bitcnt_d = 5'd0;
          done_d   = 1'b0;
          ssn_d    = 1'b0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        div_d = div_q + 1'b1;
        if (div_q == DIV_RISE) begin
          smpl_d   = smplSrc;
          bitcnt_d = bitcnt_q + 5'd1;
        end
        // bitcnt==0 at the first fall marks the porch, so no shift happens there.
        if ((div_q == DIV_FALL) && (bitcnt_q != 5'd0)) begin
          shreg_d = {shreg_q[14:0], smpl_q};
          if (bitcnt_q == 5'd16) begin
            state_d = IDLE;
            ssn_d   = 1'b1;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      shreg_q  <= '0;
      smpl_q   <= 1'b0;
      bitcnt_q <= 5'd0;
      done_q   <= 1'b0;
      ssn_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      shreg_q  <= shreg_d;
      smpl_q   <= smpl_d;
      bitcnt_q <= bitcnt_d;
      done_q   <= done_d;
      ssn_q    <= ssn_d;
    end
  end

  assign SCLK    = (state_q == IDLE) ? 1'b1 : div_q[DIV_BITS-1];
  assign MOSI    = shreg_q[15];
  assign rd_data = shreg_q;
  assign done    = done_q;
  assign SS_n    = ssn_q;

endmodule

// File: tb/tb_spi_master16.sv
// Directed bench for spi_master16: vector table plus busy-guard, back-to-back and mid-reset sequences.
// Expected read data follows SPI_MSTR_LOOPBACK_EN when that macro is defined.
module tb_spi_master16;

  localparam int DIV_BITS = 5;
  localparam int LAT      = (1 << (DIV_BITS-1)) + 16 * (1 << DIV_BITS);
  localparam int LIMIT    = LAT + 64;
`ifdef SPI_MSTR_LOOPBACK_EN
  localparam bit LOOPBACK = 1'b1;
`else
  localparam bit LOOPBACK = 1'b0;
`endif

  typedef struct {
    logic [15:0] cmd;
    logic [15:0] reply;
    logic [15:0] expRx;
    logic [15:0] expRd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wrtReg;
  logic        b2bMode;
  logic        wrt;
  logic [15:0] cmd;
  logic        MISO;
  logic        done;
  logic [15:0] rd_data;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;

  logic [15:0] slvTx;
  logic [15:0] slvRx    = '0;
  int          slvIdx   = 0;
  int          slvRises = 0;
  int          totalRises = 0;
  logic        misoBit  = 1'b0;
  logic        tieZero;
  logic        ssPrev   = 1'b1;
  logic        sclkPrev = 1'b1;

  int checks = 0;
  int fails  = 0;

  assign wrt  = b2bMode ? done : wrtReg;
  assign MISO = tieZero ? 1'b0 : misoBit;

  always #10 clk = ~clk;

  spi_master16 #(.DIV_BITS(DIV_BITS)) dut (
    .clk     (clk),
    .rst     (rst),
    .wrt     (wrt),
    .cmd     (cmd),
    .MISO    (MISO),
    .done    (done),
    .rd_data (rd_data),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI)
  );

  // Sensor model: captures MOSI on SCLK rise, presents the next reply bit after each SCLK fall.
  always @(SCLK or SS_n) begin
    if (SS_n === 1'b0 && ssPrev === 1'b1) begin
      slvIdx   = 0;
      slvRises = 0;
      slvRx    = '0;
      misoBit  = slvTx[15];
    end
    if (SCLK === 1'b1 && sclkPrev === 1'b0) begin
      totalRises++;
      if (SS_n === 1'b0) begin
        slvRx = {slvRx[14:0], MOSI};
        slvRises++;
        slvIdx++;
      end
    end
    if (SCLK === 1'b0 && sclkPrev === 1'b1 && SS_n === 1'b0 && slvIdx > 0 && slvIdx < 16)
      misoBit = slvTx[15-slvIdx];
    ssPrev   = SS_n;
    sclkPrev = SCLK;
  end

  function automatic logic [15:0] expRead(input logic [15:0] c, input logic [15:0] r);
    return LOOPBACK ? c : r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Launches one transaction (E0 is the edge after wrt rises) and runs until done, a reset edge, or the cycle limit.
  task automatic applyStimulus(input logic [15:0] c, input logic [15:0] reply, input int busyAt,
                               input logic [15:0] busyCmd, input int rstAt,
                               output int n, output bit ssnBad);
    slvTx  = reply;
    n      = 0;
    ssnBad = 1'b0;
    @(posedge clk); #1;
    wrtReg = 1'b1;
    cmd    = c;
    @(posedge clk); #1;
    wrtReg = 1'b0;
    checkOutput("ss_n_at_e0", 32'(SS_n), 32'(1'b0));
    checkOutput("mosi_at_e0", 32'(MOSI), 32'(c[15]));
    while (done !== 1'b1 && n < LIMIT) begin
      if (n == busyAt - 1) begin
        wrtReg = 1'b1;
        cmd    = busyCmd;
      end else begin
        wrtReg = 1'b0;
      end
      if (n == rstAt - 1) rst = 1'b1;
      @(posedge clk); #1;
      n++;
      if (n == rstAt) begin
        rst = 1'b0;
        break;
      end
      if (done !== 1'b1 && SS_n !== 1'b0) ssnBad = 1'b1;
    end
    wrtReg = 1'b0;
  endtask

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   n;
    bit   ssnBad;

    vecs[0] = '{cmd: 16'h0D02, reply: 16'hA5C3, expRx: 16'h0D02, expRd: expRead(16'h0D02, 16'hA5C3)};
    vecs[1] = '{cmd: 16'hFFFF, reply: 16'h0000, expRx: 16'hFFFF, expRd: expRead(16'hFFFF, 16'h0000)};
    vecs[2] = '{cmd: 16'h0000, reply: 16'hFFFF, expRx: 16'h0000, expRd: expRead(16'h0000, 16'hFFFF)};
    vecs[3] = '{cmd: 16'h8001, reply: 16'h5AA5, expRx: 16'h8001, expRd: expRead(16'h8001, 16'h5AA5)};

    rst     = 1'b1;
    wrtReg  = 1'b0;
    b2bMode = 1'b0;
    cmd     = '0;
    tieZero = 1'b0;
    slvTx   = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ss_n", 32'(SS_n), 32'(1'b1));
    checkOutput("rst_sclk", 32'(SCLK), 32'(1'b1));
    checkOutput("rst_mosi", 32'(MOSI), 32'(1'b0));
    checkOutput("rst_done", 32'(done), 32'(1'b0));
    checkOutput("rst_rd_data", 32'(rd_data), 32'h0);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("idle_no_sclk_rise", 32'(totalRises), 32'd0);
    checkOutput("idle_sclk", 32'(SCLK), 32'(1'b1));
    checkOutput("idle_ss_n", 32'(SS_n), 32'(1'b1));

    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].cmd, vecs[i].reply, -10, 16'h0, -10, n, ssnBad);
      $display("[TB] vector %0d cmd=0x%04h reply=0x%04h", i, vecs[i].cmd, vecs[i].reply);
      checkOutput("vec_latency", 32'(n), 32'(LAT));
      checkOutput("vec_rd_data", 32'(rd_data), 32'(vecs[i].expRd));
      checkOutput("vec_slave_rx", 32'(slvRx), 32'(vecs[i].expRx));
      checkOutput("vec_sclk_rises", 32'(slvRises), 32'd16);
      checkOutput("vec_ss_n_low", 32'(ssnBad), 32'd0);
      checkOutput("vec_ss_n_end", 32'(SS_n), 32'(1'b1));
    end

    // Busy guard: a second wrt mid-transaction must not disturb the frame.
    applyStimulus(16'hA200, 16'h3C96, 100, 16'hFFFF, -10, n, ssnBad);
    checkOutput("busy_latency", 32'(n), 32'(LAT));
    checkOutput("busy_slave_rx", 32'(slvRx), 32'hA200);
    checkOutput("busy_rd_data", 32'(rd_data), 32'(expRead(16'hA200, 16'h3C96)));
    repeat (2) @(posedge clk);
    #1;
    checkOutput("busy_stays_idle", 32'(SS_n), 32'(1'b1));
    checkOutput("busy_done_held", 32'(done), 32'(1'b1));

    // Back-to-back: wrt follows done combinationally.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(16'h1053, 16'h6E21, -10, 16'h0, -10, n, ssnBad);
    checkOutput("b2b1_latency", 32'(n), 32'(LAT));
    checkOutput("b2b1_slave_rx", 32'(slvRx), 32'h1053);
    checkOutput("b2b1_rd_data", 32'(rd_data), 32'(expRead(16'h1053, 16'h6E21)));
    checkOutput("b2b1_ss_n_gap", 32'(SS_n), 32'(1'b1));
    slvTx   = 16'h9C3B;
    cmd     = 16'h1150;
    b2bMode = 1'b1;
    @(posedge clk); #1;
    b2bMode = 1'b0;
    checkOutput("b2b_done_drop", 32'(done), 32'(1'b0));
    checkOutput("b2b_ss_n_restart", 32'(SS_n), 32'(1'b0));
    n = 0;
    while (done !== 1'b1 && n < LIMIT) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("b2b2_latency", 32'(n), 32'(LAT));
    checkOutput("b2b2_slave_rx", 32'(slvRx), 32'h1150);
    checkOutput("b2b2_rd_data", 32'(rd_data), 32'(expRead(16'h1150, 16'h9C3B)));
    @(posedge clk); #1;
    checkOutput("b2b2_no_restart", 32'(SS_n), 32'(1'b1));

    // Mid-transaction reset at E200, then a clean transaction.
    applyStimulus(16'h5A5A, 16'h0F0F, -10, 16'h0, 200, n, ssnBad);
    checkOutput("midrst_edge", 32'(n), 32'd200);
    checkOutput("midrst_ss_n", 32'(SS_n), 32'(1'b1));
    checkOutput("midrst_sclk", 32'(SCLK), 32'(1'b1));
    checkOutput("midrst_done", 32'(done), 32'(1'b0));
    checkOutput("midrst_mosi", 32'(MOSI), 32'(1'b0));
    checkOutput("midrst_rd_data", 32'(rd_data), 32'h0);
    applyStimulus(16'hC001, 16'h8421, -10, 16'h0, -10, n, ssnBad);
    checkOutput("postrst_latency", 32'(n), 32'(LAT));
    checkOutput("postrst_slave_rx", 32'(slvRx), 32'hC001);
    checkOutput("postrst_rd_data", 32'(rd_data), 32'(expRead(16'hC001, 16'h8421)));

`ifdef SPI_MSTR_LOOPBACK_EN
    tieZero = 1'b1;
    applyStimulus(16'h1234, 16'hFFFF, -10, 16'h0, -10, n, ssnBad);
    checkOutput("loop_latency", 32'(n), 32'(LAT));
    checkOutput("loop_rd_data", 32'(rd_data), 32'h1234);
    checkOutput("loop_slave_rx", 32'(slvRx), 32'h1234);
    tieZero = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
